// File: rtl/fp_add_postnorm.sv
// FP32 adder post-alignment stage: signed mantissa add/sub, then bit-serial renormalize.
// Optional POSTNORM_RELU_EN clamps any negative result (including -inf/-NaN) to +0.
module fp_add_postnorm #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign_a,
  input  logic                      in_sign_b,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [MANT_W:0]           in_mant_a,
  input  logic [MANT_W:0]           in_mant_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W:0]     out_result
);

  localparam int SW = MANT_W + 2;
  localparam int RW = 1 + EXP_W + MANT_W;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_NORM, S_DONE} state_t;

  state_t              r_state;
  logic                r_sign_a, r_sign_b, r_sign;
  logic [EXP_W-1:0]    r_exp;
  logic [MANT_W:0]     r_mant_a, r_mant_b;
  logic [MANT_W-1:0]   r_sum;

  logic [SW-1:0]       w_sum;
  logic                w_sign;
  logic [EXP_W-1:0]    w_exp_inc, w_exp_dec;
  logic [MANT_W:0]     w_shl;

  assign in_ready  = (r_state == S_IDLE);
  assign w_exp_inc = r_exp + 1'b1;
  assign w_exp_dec = r_exp - 1'b1;
  // NORM only runs with carry and hidden bit clear, so r_sum keeps just the fraction.
  assign w_shl     = {r_sum, 1'b0};

  always_comb begin
    w_sum  = '0;
    w_sign = r_sign_a;
    if (r_sign_a == r_sign_b) begin
      w_sum = {1'b0, r_mant_a} + {1'b0, r_mant_b};
    end else if (r_mant_a >= r_mant_b) begin
      w_sum = {1'b0, r_mant_a} - {1'b0, r_mant_b};
    end else begin
      w_sum  = {1'b0, r_mant_b} - {1'b0, r_mant_a};
      w_sign = r_sign_b;
    end
  end

  function automatic logic [RW-1:0] f_clamp(input logic [RW-1:0] v);
`ifdef POSTNORM_RELU_EN
    return v[RW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_mant_a   <= '0;
      r_mant_b   <= '0;
      r_sum      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign_a <= in_sign_a;
            r_sign_b <= in_sign_b;
            r_exp    <= in_exp;
            r_mant_a <= in_mant_a;
            r_mant_b <= in_mant_b;
            r_state  <= S_ADD;
          end
        end
        S_ADD: begin
          if (&r_exp) begin
            out_result <= f_clamp({r_sign_a, {EXP_W{1'b1}}, r_mant_a[MANT_W-1:0]});
            out_valid  <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_sum == '0) begin
            out_result <= '0;
            out_valid  <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_sum[SW-1]) begin
            if (&w_exp_inc)
              out_result <= f_clamp({w_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}});
            else
              out_result <= f_clamp({w_sign, w_exp_inc, w_sum[MANT_W:1]});
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else if (w_sum[MANT_W]) begin
            out_result <= f_clamp({w_sign, r_exp, w_sum[MANT_W-1:0]});
            out_valid  <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_sum   <= w_sum[MANT_W-1:0];
            r_sign  <= w_sign;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_sum <= w_shl[MANT_W-1:0];
          r_exp <= w_exp_dec;
          // Exponent hits zero while still unnormalized: flush instead of going subnormal.
          if (r_exp == '0 || (r_exp == EXP_W'(1) && !w_shl[MANT_W])) begin
            out_result <= '0;
            out_valid  <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_shl[MANT_W]) begin
            out_result <= f_clamp({r_sign, w_exp_dec, w_shl[MANT_W-1:0]});
            out_valid  <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_postnorm.sv
// Scoreboard bench for fp_add_postnorm: directed corner cases plus random operands
// checked against an arithmetic reference model; also backpressure and async reset.
module tb_fp_add_postnorm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign_a = 1'b0, in_sign_b = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [23:0] in_mant_a = '0, in_mant_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;

  fp_add_postnorm #(.EXP_W(8), .MANT_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign_a(in_sign_a), .in_sign_b(in_sign_b), .in_exp(in_exp),
    .in_mant_a(in_mant_a), .in_mant_b(in_mant_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   bp_mode = 1'b0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: real-number rules of the spec with plain integer arithmetic.
  task automatic ref_model(input logic sa, input logic sb, input logic [7:0] e_in,
                           input logic [23:0] ma, input logic [23:0] mb,
                           output logic [31:0] res, output int k);
    int a, b, s, e;
    logic sg;
    a = int'(ma); b = int'(mb); e = int'(e_in); k = 0;
    if (e_in == 8'hFF) begin
      res = {sa, 8'hFF, ma[22:0]};
    end else begin
      if (sa == sb) begin s = a + b; sg = sa; end
      else if (a >= b) begin s = a - b; sg = sa; end
      else begin s = b - a; sg = sb; end
      if (s == 0) res = 32'h0;
      else if (s >= (1 << 24)) begin
        e = e + 1;
        if (e >= 255) res = {sg, 8'hFF, 23'h0};
        else res = {sg, 8'(e), 23'((s >> 1) & 32'h7FFFFF)};
      end else if (s >= (1 << 23)) begin
        res = {sg, 8'(e), 23'(s & 32'h7FFFFF)};
      end else begin
        res = 32'h0;
        while (s < (1 << 23)) begin
          s = s << 1; e = e - 1; k++;
          if (e == 0 && s < (1 << 23)) break;
        end
        if (s >= (1 << 23)) res = {sg, 8'(e), 23'(s & 32'h7FFFFF)};
      end
    end
`ifdef POSTNORM_RELU_EN
    if (res[31]) res = 32'h0;
`endif
  endtask

  // Call at posedge+1 phase; returns at posedge+1 after the acceptance edge.
  task automatic issue(input logic sa, input logic sb, input logic [7:0] e,
                       input logic [23:0] ma, input logic [23:0] mb,
                       input logic [31:0] xres, input int xk, input bit push);
    int w;
    exp_t it;
    w = 0;
    while (!in_ready && w < 300) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: in_ready stuck low, expected 1");
      return;
    end
    in_sign_a = sa; in_sign_b = sb; in_exp = e; in_mant_a = ma; in_mant_b = mb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Junk on the inputs while busy must be ignored.
    in_sign_a = 1'($urandom); in_sign_b = 1'($urandom); in_exp = 8'($urandom);
    in_mant_a = 24'($urandom); in_mant_b = 24'($urandom);
    if (push) begin
      it.res = xres; it.acc = cyc; it.lat = 1 + xk;
      q.push_back(it);
    end
  endtask

  task automatic issue_rand();
    logic sa, sb;
    logic [7:0] e;
    logic [23:0] ma, mb, mf;
    logic [31:0] r, xr;
    int sel, sh, xk;
    r = $urandom; sa = r[31]; sb = r[30];
    ma = {1'b1, r[22:0]};
    r = $urandom; mf = {1'b1, r[22:0]};
    sh = $urandom_range(0, 25);
    mb = (sh >= 24) ? 24'h0 : (mf >> sh);
    if ($urandom_range(0, 4) == 0) mb = ma - 24'($urandom_range(0, 16));
    sel = $urandom_range(0, 9);
    if (sel == 0) e = 8'hFF;
    else if (sel == 1) e = 8'($urandom_range(1, 3));
    else if (sel == 2) e = 8'($urandom_range(250, 254));
    else e = 8'($urandom_range(1, 254));
    ref_model(sa, sb, e, ma, mb, xr, xk);
    issue(sa, sb, e, ma, mb, xr, xk, 1'b1);
  endtask

  // Monitor: latency on first valid, result on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", out_result);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          seen = 1'b1;
        end
        if (out_ready) begin
          chk("result", out_result, q[0].res);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!bp_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int w;
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
    chk("reset_out_result", out_result, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(0, 0, 8'd127, 24'h800000, 24'h800000, 32'h40000000, 0, 1'b1);
    issue(0, 1, 8'd127, 24'hC00000, 24'hA00000, 32'h3E800000, 2, 1'b1);
    issue(0, 1, 8'd127, 24'h800000, 24'h800000, 32'h00000000, 0, 1'b1);
    issue(0, 0, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 32'h7F800000, 0, 1'b1);
`ifdef POSTNORM_RELU_EN
    issue(0, 1, 8'd127, 24'h800000, 24'hC00000, 32'h00000000, 1, 1'b1);
    issue(1, 0, 8'd255, 24'hC00001, 24'h000001, 32'h00000000, 0, 1'b1);
`else
    issue(0, 1, 8'd127, 24'h800000, 24'hC00000, 32'hBF000000, 1, 1'b1);
    issue(1, 0, 8'd255, 24'hC00001, 24'h000001, 32'hFFC00001, 0, 1'b1);
`endif
    // Exponent runs out during NORM: flush to +0 after one shift.
    issue(1, 0, 8'd1, 24'hC00000, 24'hA00000, 32'h00000000, 1, 1'b1);

    // Backpressure: hold out_ready low while the result sits in DONE.
    w = 0;
    while (!in_ready && w < 300) begin @(posedge clk); #1; w++; end
    bp_mode = 1'b1; out_ready = 1'b0;
    issue(0, 0, 8'd127, 24'h800000, 24'h800000, 32'h40000000, 0, 1'b1);
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_out_result", out_result, 32'h40000000);
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_retire_valid", {31'b0, out_valid}, 32'h0);
    chk("bp_retire_ready", {31'b0, in_ready}, 32'h1);
    bp_mode = 1'b0;

    // Async reset during a long NORM (23 shifts) aborts without a clock edge.
    w = 0;
    while (!in_ready && w < 300) begin @(posedge clk); #1; w++; end
    issue(0, 1, 8'd127, 24'h800000, 24'h7FFFFF, 32'h0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 300; i++) issue_rand();

    w = 0;
    while (q.size() != 0 && w < 2000) begin @(posedge clk); #1; w++; end
    chk("drain", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
